// File: rtl/bip_core_ext.sv
// bip_core_ext: multi-cycle accumulator CPU (FETCH -> DECODE -> EXEC) driving
// synchronous-read program and data memories (1-cycle read latency).
// Optional macro BIP_LOGIC_OPS_EN adds AND/ANDI/OR/ORI/XOR opcodes.
// Ports: i_clk, i_rst (sync, active-high), i_start run request,
//   i_instruc / i_data_memory memory read data,
//   o_addr_program_mem (PC), o_addr_data_mem, o_data_memory (ACC),
//   o_WrRam / o_RdRam data strobes (DECODE only), o_acc,
//   o_cycle_count (saturating), o_halted (HALT state).
module bip_core_ext #(
    parameter int NB_INSTRUC = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_ADDR    = 11,
    parameter int NB_DATA    = 16,
    parameter int NB_CYCLES  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_INSTRUC-1:0] i_instruc,
    input  logic [NB_DATA-1:0]    i_data_memory,
    output logic [NB_ADDR-1:0]    o_addr_program_mem,
    output logic [NB_ADDR-1:0]    o_addr_data_mem,
    output logic [NB_DATA-1:0]    o_data_memory,
    output logic                  o_WrRam,
    output logic                  o_RdRam,
    output logic [NB_DATA-1:0]    o_acc,
    output logic [NB_CYCLES-1:0]  o_cycle_count,
    output logic                  o_halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'('h00);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'('h01);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'('h02);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'('h03);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'('h04);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'('h05);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'('h06);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'('h07);
`ifdef BIP_LOGIC_OPS_EN
    localparam logic [NB_OPCODE-1:0] OP_AND  = NB_OPCODE'('h08);
    localparam logic [NB_OPCODE-1:0] OP_ANDI = NB_OPCODE'('h09);
    localparam logic [NB_OPCODE-1:0] OP_OR   = NB_OPCODE'('h0A);
    localparam logic [NB_OPCODE-1:0] OP_ORI  = NB_OPCODE'('h0B);
    localparam logic [NB_OPCODE-1:0] OP_XOR  = NB_OPCODE'('h0C);
`endif

    state_t                 state;
    state_t                 next_state;
    logic [NB_ADDR-1:0]     pc;
    logic [NB_DATA-1:0]     acc;
    logic [NB_DATA-1:0]     acc_next;
    logic [NB_INSTRUC-1:0]  ir;
    logic [NB_CYCLES-1:0]   cycle_count;
    logic [NB_CYCLES-1:0]   cycle_inc;

    logic [NB_OPCODE-1:0]   dec_op;
    logic [NB_ADDR-1:0]     dec_operand;
    logic [NB_OPCODE-1:0]   ir_op;
    logic [NB_ADDR-1:0]     ir_operand;
    logic [NB_DATA-1:0]     imm_ext;

    function automatic logic reads_mem(input logic [NB_OPCODE-1:0] op);
        logic r;
        r = (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
`ifdef BIP_LOGIC_OPS_EN
        r = r || (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
`endif
        return r;
    endfunction

    // In DECODE the fetched word is only on i_instruc (IR loads at the
    // end of DECODE), so data address and strobes decode it directly.
    assign dec_op      = i_instruc[NB_INSTRUC-1 -: NB_OPCODE];
    assign dec_operand = i_instruc[NB_ADDR-1:0];
    assign ir_op       = ir[NB_INSTRUC-1 -: NB_OPCODE];
    assign ir_operand  = ir[NB_ADDR-1:0];
    assign imm_ext     = {{(NB_DATA-NB_ADDR){ir_operand[NB_ADDR-1]}},
                          ir_operand};

    assign cycle_inc = (&cycle_count) ? cycle_count
                                      : cycle_count + NB_CYCLES'(1);

    // Next state and memory strobes. Strobes are masked by i_rst so a
    // reset landing in DECODE cannot commit a store on that edge.
    always_comb begin
        next_state      = state;
        o_RdRam         = 1'b0;
        o_WrRam         = 1'b0;
        o_addr_data_mem = ir_operand;
        unique case (state)
            IDLE, HALT: begin
                if (i_start) next_state = FETCH;
            end
            FETCH: begin
                next_state = DECODE;
            end
            DECODE: begin
                o_addr_data_mem = dec_operand;
                o_RdRam = !i_rst && reads_mem(dec_op);
                o_WrRam = !i_rst && (dec_op == OP_STO);
                next_state = (dec_op == OP_HLT) ? HALT : EXEC;
            end
            EXEC: begin
                next_state = FETCH;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (i_rst) next_state = IDLE;
    end

    always_comb begin
        acc_next = acc;
        unique case (ir_op)
            OP_LD:   acc_next = i_data_memory;
            OP_LDI:  acc_next = imm_ext;
            OP_ADD:  acc_next = acc + i_data_memory;
            OP_ADDI: acc_next = acc + imm_ext;
            OP_SUB:  acc_next = acc - i_data_memory;
            OP_SUBI: acc_next = acc - imm_ext;
`ifdef BIP_LOGIC_OPS_EN
            OP_AND:  acc_next = acc & i_data_memory;
            OP_ANDI: acc_next = acc & imm_ext;
            OP_OR:   acc_next = acc | i_data_memory;
            OP_ORI:  acc_next = acc | imm_ext;
            OP_XOR:  acc_next = acc ^ i_data_memory;
`endif
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc          <= '0;
            acc         <= '0;
            ir          <= '0;
            cycle_count <= '0;
        end else begin
            unique case (state)
                IDLE, HALT: begin
                    if (i_start) begin
                        pc          <= '0;
                        acc         <= '0;
                        cycle_count <= '0;
                    end
                end
                FETCH: begin
                    cycle_count <= cycle_inc;
                end
                DECODE: begin
                    ir          <= i_instruc;
                    cycle_count <= cycle_inc;
                end
                EXEC: begin
                    acc         <= acc_next;
                    pc          <= pc + NB_ADDR'(1);
                    cycle_count <= cycle_inc;
                end
                default: begin
                    cycle_count <= cycle_count;
                end
            endcase
        end
    end

    assign o_addr_program_mem = pc;
    assign o_data_memory      = acc;
    assign o_acc              = acc;
    assign o_cycle_count      = cycle_count;
    assign o_halted           = (state == HALT);

endmodule

// File: doc/bip_core_ext.md
BIP_CORE_EXT -- requirements
Module: bip_core_ext

Interface
REQ-001 SHALL have parameter NB_INSTRUC, default 16, instruction width.
REQ-002 SHALL have parameter NB_OPCODE, default 5, opcode field width (instruction MSBs); operand = remaining NB_INSTRUC-NB_OPCODE LSBs.
REQ-003 SHALL have parameter NB_ADDR, default 11, program/data address width; equals operand width.
REQ-004 SHALL have parameter NB_DATA, default 16, accumulator/data width.
REQ-005 SHALL have parameter NB_CYCLES, default 32, cycle-counter width.
REQ-006 SHALL have ports: i_clk input 1 clock; i_rst input 1 reset; i_start input 1 run request; i_instruc input NB_INSTRUC program-memory read data; i_data_memory input NB_DATA data-memory read data; o_addr_program_mem output NB_ADDR PC; o_addr_data_mem output NB_ADDR data address; o_data_memory output NB_DATA write data (=ACC); o_WrRam output 1 data write enable; o_RdRam output 1 data read enable; o_acc output NB_DATA accumulator; o_cycle_count output NB_CYCLES executed cycles; o_halted output 1 HLT reached.
REQ-007 SHALL use one clock, i_clk, with reset i_rst synchronous and active-high.

Function
REQ-008 SHALL assume both memories have 1-cycle synchronous read latency (address at edge N, data valid after edge N+1).
REQ-009 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-010 IDLE/HALT: i_start=1 -> FETCH with PC=0, ACC=0, o_cycle_count=0, o_halted=0; i_start=0 -> stay.
REQ-011 FETCH: drive o_addr_program_mem=PC; -> DECODE.
REQ-012 DECODE: latch i_instruc into IR; drive o_addr_data_mem=operand; o_RdRam=1 for LD/ADD/SUB; o_WrRam=1 for STO (write of ACC at this edge); HLT -> HALT, else -> EXEC.
REQ-013 EXEC: update ACC per opcode, PC<=PC+1, -> FETCH; each non-HLT instruction takes exactly 3 cycles.
REQ-014 Opcodes: 00000 HLT; 00001 STO mem[op]<=ACC; 00010 LD ACC<=mem[op]; 00011 LDI ACC<=sext(op); 00100 ADD ACC+=mem[op]; 00101 ADDI ACC+=sext(op); 00110 SUB ACC-=mem[op]; 00111 SUBI ACC-=sext(op).
REQ-015 Immediate operands SHALL be sign-extended to NB_DATA; arithmetic SHALL be modulo 2^NB_DATA, no flags.
REQ-016 Undefined opcodes SHALL execute as NOP (3 cycles, PC+1, no memory access).
REQ-017 PC SHALL wrap from 2^NB_ADDR-1 to 0.
REQ-018 o_RdRam/o_WrRam SHALL be 0 outside DECODE; never both 1.
REQ-019 o_cycle_count SHALL increment once per cycle in FETCH/DECODE/EXEC, saturate at all-ones, hold in IDLE/HALT.
REQ-020 o_halted SHALL be 1 exactly in HALT.
REQ-021 i_start SHALL be ignored in FETCH/DECODE/EXEC.

Reset
REQ-022 i_rst=1 at an edge SHALL force IDLE, PC=0, ACC=0, IR=0, o_cycle_count=0, o_halted=0, o_RdRam=0, o_WrRam=0.
REQ-023 Reset mid-instruction SHALL abort it: no ACC/PC update and no memory write after the reset edge.
REQ-024 i_rst SHALL take priority over i_start.

Configuration
REQ-025 Macro BIP_LOGIC_OPS_EN defined: opcodes 01000 AND, 01001 ANDI, 01010 OR, 01011 ORI, 01100 XOR (bitwise with mem[op] or sext(op)), 3 cycles, o_RdRam=1 for memory forms.
REQ-026 Macro undefined: opcodes 01000-01100 SHALL behave as NOP per REQ-016.

Verification
REQ-027 Program LDI 5; ADDI -2; STO 3; HLT; pulse i_start -> mem[3]=3, o_acc=3, o_halted=1, o_cycle_count=11.
REQ-028 mem[7]=0x7FFF; LD 7; ADDI 1; HLT -> o_acc=0x8000 (wrap, no flag).
REQ-029 Reset asserted in DECODE of STO 3 -> mem[3] unchanged, state IDLE, all outputs at reset values.
REQ-030 2048 NOPs (opcode 11111) then HLT at address 0 -> PC wraps to 0, halts, o_cycle_count=6146.
REQ-031 With BIP_LOGIC_OPS_EN: LDI 0x0F0; ANDI 0x03C; HLT -> o_acc=0x030; without macro -> o_acc=0x0F0.
REQ-032 i_start held high during run -> no restart; after HALT, i_start -> PC=0, ACC=0, counter cleared.
